ctrl_ramdrv_header_mc: RTL and testbench

- Multi-channel ring-buffer head-pointer controller for the sample-RAM driver.
- Each channel has its own buffer length, its own head, and a variable advance step, so it supports interpolation/decimation strides.
- Provides a registered tap-address lookup: (head + tap) mod buffer size.
- Sits between the SRC controller FSM and the RAM address generator.

---
 rtl/ctrl_ramdrv_header_mc.sv | 127 ++++++++++++
 tb/tb_ctrl_ramdrv_header_mc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_ramdrv_header_mc.sv
// Multi-channel ring-buffer head-pointer controller for the sample-RAM driver.
// Each channel keeps a buffer length and a head. Heads advance by a variable step
// and wrap modulo (length+1). Registered tap-address lookups return
// (head + tap) mod (length+1).
module ctrl_ramdrv_header_mc #(
    parameter int unsigned DATA_OFFSET_WIDTH  = 10,
    parameter int unsigned VECTOR_INDEX_WIDTH = 4,
    parameter int unsigned STEP_WIDTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [VECTOR_INDEX_WIDTH-1:0] cfg_index,
    input  logic [DATA_OFFSET_WIDTH-1:0]  cfg_length,
    input  logic                          inc_en,
    input  logic [VECTOR_INDEX_WIDTH-1:0] inc_index,
    input  logic [STEP_WIDTH-1:0]         inc_step,
    input  logic                          rd_req,
    input  logic [VECTOR_INDEX_WIDTH-1:0] rd_index,
    input  logic [DATA_OFFSET_WIDTH-1:0]  rd_tap,
    output logic                          rd_valid,
    output logic [DATA_OFFSET_WIDTH-1:0]  rd_offset,
    output logic                          wrap,
    output logic                          err
);

    localparam int unsigned DW  = DATA_OFFSET_WIDTH;
    localparam int unsigned SW  = DATA_OFFSET_WIDTH + 1;
    localparam int unsigned IW  = VECTOR_INDEX_WIDTH;
    localparam int unsigned NCH = 1 << VECTOR_INDEX_WIDTH;

    logic [DW-1:0] length_q [NCH];
    logic [DW-1:0] head_q   [NCH];

    // Advance path: one extra bit keeps the sum and buffer size exact
    logic [DW-1:0] inc_len;
    logic [DW-1:0] inc_head;
    logic [SW-1:0] inc_size;
    logic [SW-1:0] inc_step_x;
    logic [SW-1:0] inc_sum;
    logic          inc_illegal;
    logic          inc_wrap;
    logic          inc_blocked;
    logic [DW-1:0] inc_next;

    // Read path: same single-subtract modulo on the pre-update state
    logic [DW-1:0] rd_len;
    logic [DW-1:0] rd_head;
    logic [SW-1:0] rd_size;
    logic [SW-1:0] rd_sum;
    logic          rd_illegal;
    logic [DW-1:0] rd_next;

    // Compute next head for the advancing channel
    always_comb begin
        inc_len     = length_q[inc_index];
        inc_head    = head_q[inc_index];
        inc_size    = SW'(inc_len) + SW'(1);
        inc_step_x  = SW'(inc_step);
        inc_sum     = SW'(inc_head) + inc_step_x;
        inc_illegal = inc_step_x > inc_size;
        inc_wrap    = inc_sum > SW'(inc_len);
        inc_blocked = cfg_we && (cfg_index == inc_index);
        inc_next    = inc_wrap ? DW'(inc_sum - inc_size) : DW'(inc_sum);
    end

    // Compute tap address for the read channel
    always_comb begin
        rd_len     = length_q[rd_index];
        rd_head    = head_q[rd_index];
        rd_size    = SW'(rd_len) + SW'(1);
        rd_sum     = SW'(rd_head) + SW'(rd_tap);
        rd_illegal = rd_tap > rd_len;
        if (rd_illegal) begin
            rd_next = rd_head;
        end else if (rd_sum > SW'(rd_len)) begin
            rd_next = DW'(rd_sum - rd_size);
        end else begin
            rd_next = DW'(rd_sum);
        end
    end

    // Per-channel length/head storage; configuration overrides an advance on the same channel
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                length_q[IW'(c)] <= '0;
                head_q[IW'(c)]   <= '0;
            end
        end else begin
            if (inc_en && !inc_blocked && !inc_illegal) begin
                head_q[inc_index] <= inc_next;
            end
            if (cfg_we) begin
                length_q[cfg_index] <= cfg_length;
                head_q[cfg_index]   <= '0;
            end
        end
    end

    // Registered read result, wrap pulse and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            rd_offset <= '0;
            wrap      <= 1'b0;
            err       <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            wrap     <= 1'b0;
            if (rd_req) begin
                rd_offset <= rd_next;
                if (rd_illegal) begin
                    err <= 1'b1;
                end
            end
            if (inc_en && !inc_blocked) begin
                if (inc_illegal) begin
                    err <= 1'b1;
                end else begin
                    wrap <= inc_wrap;
                end
            end
        end
    end

endmodule

// File: tb/tb_ctrl_ramdrv_header_mc.sv
// Testbench for ctrl_ramdrv_header_mc: directed vector table plus a randomized
// phase checked against a modulo-based reference model through a scoreboard queue.
module tb_ctrl_ramdrv_header_mc;

    localparam int unsigned DW = 10;
    localparam int unsigned IW = 4;
    localparam int unsigned SW = 4;
    localparam int unsigned NCH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [IW-1:0] cfg_index;
    logic [DW-1:0] cfg_length;
    logic          inc_en;
    logic [IW-1:0] inc_index;
    logic [SW-1:0] inc_step;
    logic          rd_req;
    logic [IW-1:0] rd_index;
    logic [DW-1:0] rd_tap;
    logic          rd_valid;
    logic [DW-1:0] rd_offset;
    logic          wrap;
    logic          err;

    ctrl_ramdrv_header_mc #(
        .DATA_OFFSET_WIDTH (DW),
        .VECTOR_INDEX_WIDTH(IW),
        .STEP_WIDTH        (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_index (cfg_index),
        .cfg_length(cfg_length),
        .inc_en    (inc_en),
        .inc_index (inc_index),
        .inc_step  (inc_step),
        .rd_req    (rd_req),
        .rd_index  (rd_index),
        .rd_tap    (rd_tap),
        .rd_valid  (rd_valid),
        .rd_offset (rd_offset),
        .wrap      (wrap),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rs;
        logic          cw;
        logic [IW-1:0] ci;
        logic [DW-1:0] cl;
        logic          ie;
        logic [IW-1:0] ii;
        logic [SW-1:0] is;
        logic          rr;
        logic [IW-1:0] ri;
        logic [DW-1:0] rt;
        logic          ev;
        logic [DW-1:0] eo;
        logic          ew;
        logic          ee;
    } vec_t;

    typedef struct {
        logic          ev;
        logic [DW-1:0] eo;
        logic          ew;
        logic          ee;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model state
    int   m_len  [NCH];
    int   m_head [NCH];
    int   m_off;
    logic m_err;

    function automatic vec_t mk(input logic rs, input logic cw, input int ci, input int cl,
                                input logic ie, input int ii, input int is,
                                input logic rr, input int ri, input int rt,
                                input logic ev, input int eo, input logic ew, input logic ee);
        vec_t v;
        v.rs = rs; v.cw = cw; v.ci = IW'(ci); v.cl = DW'(cl);
        v.ie = ie; v.ii = IW'(ii); v.is = SW'(is);
        v.rr = rr; v.ri = IW'(ri); v.rt = DW'(rt);
        v.ev = ev; v.eo = DW'(eo); v.ew = ew; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic drive(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        rst = v.rs; cfg_we = v.cw; cfg_index = v.ci; cfg_length = v.cl;
        inc_en = v.ie; inc_index = v.ii; inc_step = v.is;
        rd_req = v.rr; rd_index = v.ri; rd_tap = v.rt;
        e.ev = v.ev; e.eo = v.eo; e.ew = v.ew; e.ee = v.ee;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard vec %0d: queue empty", idx);
        end else begin
            got = sb_q.pop_front();
            chk("rd_valid", idx, int'(rd_valid), int'(got.ev));
            chk("rd_offset", idx, int'(rd_offset), int'(got.eo));
            chk("wrap", idx, int'(wrap), int'(got.ew));
            chk("err", idx, int'(err), int'(got.ee));
        end
    endtask

    // Reference model: read-before-write, cfg beats inc on the same channel
    task automatic model_step(inout vec_t v);
        int  sum;
        logic w;
        w = 1'b0;
        if (v.rs) begin
            for (int c = 0; c < NCH; c++) begin
                m_len[c] = 0; m_head[c] = 0;
            end
            m_off = 0; m_err = 1'b0;
            v.ev = 1'b0;
        end else begin
            v.ev = v.rr;
            if (v.rr) begin
                if (int'(v.rt) > m_len[v.ri]) begin
                    m_off = m_head[v.ri]; m_err = 1'b1;
                end else begin
                    m_off = (m_head[v.ri] + int'(v.rt)) % (m_len[v.ri] + 1);
                end
            end
            if (v.ie && !(v.cw && v.ci == v.ii)) begin
                if (int'(v.is) > m_len[v.ii] + 1) begin
                    m_err = 1'b1;
                end else begin
                    sum = m_head[v.ii] + int'(v.is);
                    w = sum > m_len[v.ii];
                    m_head[v.ii] = sum % (m_len[v.ii] + 1);
                end
            end
            if (v.cw) begin
                m_len[v.ci] = int'(v.cl); m_head[v.ci] = 0;
            end
        end
        v.eo = DW'(m_off); v.ew = w; v.ee = m_err;
    endtask

    vec_t tbl[33];

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_index = '0; cfg_length = '0;
        inc_en = 1'b0; inc_index = '0; inc_step = '0;
        rd_req = 1'b0; rd_index = '0; rd_tap = '0;

        //            rs cw ci cl  ie ii is rr ri rt   ev eo  ew ee
        tbl[0]  = mk(1, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0);
        tbl[1]  = mk(0, 1, 3, 7,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0);
        tbl[2]  = mk(0, 0, 0, 0,  1, 3, 3, 0, 0, 0,  0, 0,  0, 0);
        tbl[3]  = mk(0, 0, 0, 0,  1, 3, 3, 0, 0, 0,  0, 0,  0, 0);
        tbl[4]  = mk(0, 0, 0, 0,  1, 3, 3, 0, 0, 0,  0, 0,  1, 0);
        tbl[5]  = mk(0, 0, 0, 0,  0, 0, 0, 1, 3, 0,  1, 1,  0, 0);
        tbl[6]  = mk(0, 0, 0, 0,  0, 0, 0, 1, 3, 7,  1, 0,  0, 0);
        tbl[7]  = mk(0, 0, 0, 0,  0, 0, 0, 1, 3, 8,  1, 1,  0, 1);
        tbl[8]  = mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 1,  0, 1);
        tbl[9]  = mk(0, 1, 2, 9,  0, 0, 0, 0, 0, 0,  0, 1,  0, 1);
        tbl[10] = mk(0, 0, 0, 0,  1, 2, 8, 0, 0, 0,  0, 1,  0, 1);
        tbl[11] = mk(0, 1, 5, 4,  1, 5, 2, 0, 0, 0,  0, 1,  0, 1);
        tbl[12] = mk(0, 1, 6, 1,  1, 2, 2, 0, 0, 0,  0, 1,  1, 1);
        tbl[13] = mk(0, 0, 0, 0,  0, 0, 0, 1, 5, 0,  1, 0,  0, 1);
        tbl[14] = mk(0, 0, 0, 0,  0, 0, 0, 1, 2, 0,  1, 0,  0, 1);
        tbl[15] = mk(0, 0, 0, 0,  0, 0, 0, 1, 6, 1,  1, 1,  0, 1);
        tbl[16] = mk(0, 1, 0, 15, 0, 0, 0, 0, 0, 0,  0, 1,  0, 1);
        tbl[17] = mk(0, 0, 0, 0,  1, 0, 14,0, 0, 0,  0, 1,  0, 1);
        tbl[18] = mk(0, 0, 0, 0,  1, 0, 1, 1, 0, 0,  1, 14, 0, 1);
        tbl[19] = mk(0, 0, 0, 0,  0, 0, 0, 1, 0, 0,  1, 15, 0, 1);
        tbl[20] = mk(1, 0, 0, 0,  1, 0, 1, 1, 0, 0,  0, 0,  0, 0);
        tbl[21] = mk(0, 0, 0, 0,  0, 0, 0, 1, 0, 0,  1, 0,  0, 0);
        tbl[22] = mk(0, 0, 0, 0,  0, 0, 0, 1, 3, 0,  1, 0,  0, 0);
        tbl[23] = mk(0, 1, 1, 2,  0, 0, 0, 0, 0, 0,  0, 0,  0, 0);
        tbl[24] = mk(0, 0, 0, 0,  1, 1, 4, 0, 0, 0,  0, 0,  0, 1);
        tbl[25] = mk(0, 0, 0, 0,  0, 0, 0, 1, 1, 0,  1, 0,  0, 1);
        tbl[26] = mk(0, 1, 1, 0,  0, 0, 0, 0, 0, 0,  0, 0,  0, 1);
        tbl[27] = mk(0, 0, 0, 0,  1, 1, 1, 0, 0, 0,  0, 0,  1, 1);
        tbl[28] = mk(0, 0, 0, 0,  1, 1, 1, 0, 0, 0,  0, 0,  1, 1);
        tbl[29] = mk(0, 0, 0, 0,  0, 0, 0, 1, 1, 0,  1, 0,  0, 1);
        tbl[30] = mk(1, 1, 4, 9,  1, 4, 1, 1, 4, 0,  0, 0,  0, 0);
        tbl[31] = mk(0, 0, 0, 0,  0, 0, 0, 1, 4, 0,  1, 0,  0, 0);
        tbl[32] = mk(0, 0, 0, 0,  1, 1, 0, 0, 0, 0,  0, 0,  0, 0);

        @(negedge clk);
        for (int i = 0; i < 33; i++) begin
            drive(tbl[i], i);
        end

        // Randomized phase: few channels to force collisions, small lengths to force wraps
        begin
            vec_t v;
            v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            model_step(v);
            drive(v, 100);
            for (int i = 0; i < 400; i++) begin
                v.rs = ($urandom_range(0, 99) == 0);
                v.cw = ($urandom_range(0, 5) == 0);
                v.ci = IW'($urandom_range(0, 3));
                v.cl = DW'($urandom_range(0, 12));
                v.ie = ($urandom_range(0, 1) == 1);
                v.ii = IW'($urandom_range(0, 3));
                v.is = SW'($urandom_range(0, 15));
                v.rr = ($urandom_range(0, 2) != 0);
                v.ri = IW'($urandom_range(0, 3));
                v.rt = DW'($urandom_range(0, 14));
                if (v.ie && v.is > 4'd3 && $urandom_range(0, 3) != 0) begin
                    v.is = SW'($urandom_range(0, 3));
                end
                model_step(v);
                drive(v, 101 + i);
            end
        end

        rst = 1'b0; cfg_we = 1'b0; inc_en = 1'b0; rd_req = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
